// File: rtl/sic_dispatch_arb.sv
// SIC dispatch arbiter: stages one issued packet, hands it to an idle SIC round-robin,
// and merges SIC PC redirects (oldest issue_id wins). Optional counters: SIC_DISPATCH_STATS_EN.

package sic_pkg;
  localparam int PKT_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [PKT_ID_W-1:0] issue_id;
    logic [31:0]         instr;
  } sic_packet_t;
endpackage

module sic_dispatch_arb
  import sic_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int ID_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue_valid,
  input  sic_packet_t                       issue_pkt,
  output logic                              issue_ready,
  input  logic [NUM_SIC-1:0]                sic_req_instr,
  output sic_packet_t [NUM_SIC-1:0]         sic_pkt,
  input  logic [NUM_SIC-1:0]                sic_redir_valid,
  input  logic [NUM_SIC-1:0][31:0]          sic_redir_pc,
  input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]  sic_redir_id,
  output logic                              redirect_valid,
  output logic [31:0]                       redirect_pc,
  output logic [ID_WIDTH-1:0]               redirect_issue_id
`ifdef SIC_DISPATCH_STATS_EN
  ,
  output logic [31:0]                       stat_dispatch,
  output logic [31:0]                       stat_redirect,
  output logic [31:0]                       stat_stall
`endif
);

  localparam int PTR_W = $clog2(NUM_SIC);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]         state;
  logic               stage_valid;
  sic_packet_t        stage_pkt;
  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_SIC-1:0] eligible;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_rr;
  logic               dispatch_fire;
  logic               accept;
  logic               any_redir;
  logic [PTR_W-1:0]   redir_win;
  sic_packet_t        dispatch_pkt;

  // Wrap-aware age compare: a is older than b when (a - b) lands in the upper half.
  function automatic logic id_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ID_WIDTH-1];
  endfunction

  // A SIC whose pulse is still in flight has not yet seen its packet and must not be re-granted.
  always_comb begin
    for (int i = 0; i < NUM_SIC; i++) begin
      eligible[i] = sic_req_instr[i] && !sic_pkt[i].valid;
    end
  end

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SIC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SIC;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign next_rr = (int'(grant_idx) == NUM_SIC - 1) ? '0 : grant_idx + PTR_W'(1);

  // Strict "older" keeps the lowest index on equal IDs.
  always_comb begin
    logic found;
    found     = 1'b0;
    redir_win = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      if (sic_redir_valid[i] && (!found || id_older(sic_redir_id[i], sic_redir_id[redir_win]))) begin
        found     = 1'b1;
        redir_win = PTR_W'(i);
      end
    end
  end

  assign any_redir     = |sic_redir_valid;
  assign dispatch_fire = (state == ST_RUN) && stage_valid && grant_found && !any_redir;
  assign issue_ready   = rst_n && (state == ST_RUN) && (!stage_valid || dispatch_fire);
  assign accept        = issue_valid && issue_ready;

  always_comb begin
    dispatch_pkt       = stage_pkt;
    dispatch_pkt.valid = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_RUN;
      stage_valid       <= 1'b0;
      stage_pkt         <= '0;
      rr_ptr            <= '0;
      sic_pkt           <= '0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      redirect_issue_id <= '0;
    end else begin
      state <= any_redir ? ST_FLUSH : ST_RUN;

      for (int i = 0; i < NUM_SIC; i++) begin
        if (dispatch_fire && (grant_idx == PTR_W'(i))) begin
          sic_pkt[i] <= dispatch_pkt;
        end else begin
          sic_pkt[i].valid <= 1'b0;
        end
      end
      if (dispatch_fire) begin
        rr_ptr <= next_rr;
      end

      // The flush cycle discards whatever was staged: it is younger than the redirecting instruction.
      if (state == ST_FLUSH) begin
        stage_valid <= 1'b0;
      end else if (accept) begin
        stage_valid <= 1'b1;
        stage_pkt   <= issue_pkt;
      end else if (dispatch_fire) begin
        stage_valid <= 1'b0;
      end

      redirect_valid <= any_redir;
      if (any_redir) begin
        redirect_pc       <= sic_redir_pc[redir_win];
        redirect_issue_id <= sic_redir_id[redir_win];
      end
    end
  end

`ifdef SIC_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_dispatch <= '0;
      stat_redirect <= '0;
      stat_stall    <= '0;
    end else begin
      if (dispatch_fire) begin
        stat_dispatch <= stat_dispatch + 32'd1;
      end
      if (redirect_valid) begin
        stat_redirect <= stat_redirect + 32'd1;
      end
      if (stage_valid && (state == ST_RUN) && !dispatch_fire) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
